btn_event_scheduler: RTL and testbench

Collects the debounced levels of N_BTN game buttons and turns each press into a discrete event. Events are queued in a small FIFO and handed to game logic over a valid/ready handshake. Simultaneous presses are serialized by a round-robin arbiter, so no button is starved. The block sits between the per-button debounce instances and the game state machine.

---
 rtl/btn_event_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_btn_event_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_scheduler.sv
// btn_event_scheduler
// Turns rising edges of debounced button levels into discrete events,
// serializes simultaneous presses with a round-robin arbiter and queues
// them in a small FIFO drained over a valid/ready handshake.
// Optional auto-repeat is built only when AUTO_REPEAT_EN is defined; without
// it, no hold counters exist and every event is a press (evt_kind = 0).
module btn_event_scheduler #(
    parameter int unsigned ID_W         = 2,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [23:0] REPEAT_DELAY = 24'd6_000_000,
    parameter logic [23:0] REPEAT_RATE  = 24'd1_500_000,
    localparam int unsigned N_BTN       = 2 ** ID_W,
    localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W       = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_BTN-1:0]   btn_level,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [ID_W-1:0]    evt_id,
    output logic               evt_kind,
    output logic [CNT_W-1:0]   evt_count,
    output logic               ovf,
    input  logic               ovf_clr
);

    // FIFO entry layout: {id, kind}
    logic [N_BTN-1:0]                btn_prev_q, btn_prev_d;
    logic [N_BTN-1:0]                pending_q, pending_d;
    logic [N_BTN-1:0]                pend_kind_q, pend_kind_d;
    logic [ID_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                count_q, count_d;
    logic [FIFO_DEPTH-1:0][ID_W:0]   mem_q, mem_d;
    logic [ID_W:0]                   last_q, last_d;
    logic                            ovf_q, ovf_d;

    logic [N_BTN-1:0]                req;
    logic [N_BTN-1:0]                req_kind;
    logic                            pop;
    logic                            full;
    logic                            push_ok;
    logic                            gnt_vld;
    logic [ID_W-1:0]                 gnt_id;
    logic [ID_W-1:0]                 arb_idx;
    logic                            drop;
    logic [ID_W:0]                   head;

`ifdef AUTO_REPEAT_EN
    logic [N_BTN-1:0][23:0]          hold_cnt_q, hold_cnt_d;
    logic [N_BTN-1:0]                rep_phase_q, rep_phase_d;

    // Press requests from rising edges plus repeat requests from the hold counters.
    always_comb begin
        btn_prev_d  = btn_level;
        req         = btn_level & ~btn_prev_q;
        req_kind    = '0;
        hold_cnt_d  = '0;
        rep_phase_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (btn_level[i] && btn_prev_q[i]) begin
                hold_cnt_d[i]  = hold_cnt_q[i] + 24'd1;
                rep_phase_d[i] = rep_phase_q[i];
                // first target is the initial delay, then the repeat period
                if (hold_cnt_d[i] == (rep_phase_q[i] ? REPEAT_RATE : REPEAT_DELAY)) begin
                    req[i]         = 1'b1;
                    req_kind[i]    = 1'b1;
                    hold_cnt_d[i]  = '0;
                    rep_phase_d[i] = 1'b1;
                end
            end
        end
    end
`else
    // Press requests from rising edges only.
    always_comb begin
        btn_prev_d = btn_level;
        req        = btn_level & ~btn_prev_q;
        req_kind   = '0;
    end
`endif

    // Round-robin grant: first pending index at or above rr_ptr, cyclically.
    always_comb begin
        evt_valid = (count_q != '0);
        pop       = evt_valid && evt_ready;
        full      = (count_q == CNT_W'(FIFO_DEPTH));
        push_ok   = !full || pop;
        gnt_vld   = 1'b0;
        gnt_id    = '0;
        arb_idx   = '0;
        // scan downward so the lowest offset from rr_ptr is the one that sticks
        for (int j = N_BTN - 1; j >= 0; j--) begin
            arb_idx = rr_ptr_q + ID_W'(j);
            if (pending_q[arb_idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = arb_idx;
            end
        end
        if (!push_ok) begin
            gnt_vld = 1'b0;
        end
    end

    // Pending flags, drop detection, sticky overflow and pointer advance.
    always_comb begin
        pending_d   = pending_q;
        pend_kind_d = pend_kind_q;
        rr_ptr_d    = rr_ptr_q;
        drop        = 1'b0;
        if (gnt_vld) begin
            pending_d[gnt_id] = 1'b0;
            rr_ptr_d          = gnt_id + ID_W'(1);
        end
        // a request landing on a just-granted slot re-arms it instead of dropping
        for (int i = 0; i < N_BTN; i++) begin
            if (req[i]) begin
                if (pending_d[i]) begin
                    drop = 1'b1;
                end else begin
                    pending_d[i]   = 1'b1;
                    pend_kind_d[i] = req_kind[i];
                end
            end
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Event FIFO; the last popped entry is kept so outputs hold while empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        last_d   = last_q;
        if (gnt_vld) begin
            mem_d[wr_ptr_q] = {gnt_id, pend_kind_q[gnt_id]};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            last_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({gnt_vld, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Output decode from the FIFO head or the held last entry.
    always_comb begin
        head      = evt_valid ? mem_q[rd_ptr_q] : last_q;
        evt_id    = head[ID_W:1];
        evt_kind  = head[0];
        evt_count = count_q;
        ovf       = ovf_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev_q  <= '0;
            pending_q   <= '0;
            pend_kind_q <= '0;
            rr_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_q       <= '0;
            last_q      <= '0;
            ovf_q       <= 1'b0;
`ifdef AUTO_REPEAT_EN
            hold_cnt_q  <= '0;
            rep_phase_q <= '0;
`endif
        end else begin
            btn_prev_q  <= btn_prev_d;
            pending_q   <= pending_d;
            pend_kind_q <= pend_kind_d;
            rr_ptr_q    <= rr_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_q       <= mem_d;
            last_q      <= last_d;
            ovf_q       <= ovf_d;
`ifdef AUTO_REPEAT_EN
            hold_cnt_q  <= hold_cnt_d;
            rep_phase_q <= rep_phase_d;
`endif
        end
    end

endmodule

// File: tb/tb_btn_event_scheduler.sv
// Testbench for btn_event_scheduler: queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_btn_event_scheduler;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int DLY   = 10;
    localparam int RATE  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_level = 4'b0000;
    logic       evt_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_kind;
    logic [2:0] evt_count;
    logic       ovf;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    btn_event_scheduler #(
        .ID_W         (2),
        .FIFO_DEPTH   (DEPTH),
        .REPEAT_DELAY (24'd10),
        .REPEAT_RATE  (24'd4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_level (btn_level),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_kind  (evt_kind),
        .evt_count (evt_count),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: events as id*2+kind in a queue
    int   m_q[$];
    bit   m_pend[N];
    int   m_kind[N];
    int   m_hold[N];
    int   m_rr;
    int   m_ovf;
    int   m_last;
    logic [3:0] m_prev;

    always @(posedge clk) begin
        int g;
        bit pop;
        bit drop;
        bit [3:0] req;
        int rk[N];
        if (rst) begin
            m_q.delete();
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 1'b0;
                m_kind[i] = 0;
                m_hold[i] = 0;
            end
            m_rr = 0;
            m_ovf = 0;
            m_last = 0;
            m_prev = 4'b0000;
        end else begin
            pop = (m_q.size() != 0) && evt_ready;
            g = -1;
            if (m_q.size() < DEPTH || pop) begin
                for (int j = 0; j < N; j++) begin
                    if (g < 0 && m_pend[(m_rr + j) % N]) g = (m_rr + j) % N;
                end
            end
            for (int i = 0; i < N; i++) begin
                req[i] = btn_level[i] && !m_prev[i];
                rk[i] = 0;
                if (!btn_level[i] || req[i]) m_hold[i] = 0;
                else m_hold[i] = m_hold[i] + 1;
`ifdef AUTO_REPEAT_EN
                if (btn_level[i] && !req[i] && m_hold[i] >= DLY && ((m_hold[i] - DLY) % RATE) == 0) begin
                    req[i] = 1'b1;
                    rk[i] = 1;
                end
`endif
            end
            drop = 1'b0;
            if (pop) begin
                m_last = m_q[0];
                void'(m_q.pop_front());
            end
            if (g >= 0) begin
                m_q.push_back(g * 2 + m_kind[g]);
                m_pend[g] = 1'b0;
                m_rr = (g + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (m_pend[i]) drop = 1'b1;
                    else begin
                        m_pend[i] = 1'b1;
                        m_kind[i] = rk[i];
                    end
                end
            end
            if (drop) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
            m_prev = btn_level;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        int head;
        if (cmp_en) begin
            head = (m_q.size() != 0) ? m_q[0] : m_last;
            chk("m_valid", evt_valid, (m_q.size() != 0) ? 1 : 0);
            chk("m_count", evt_count, m_q.size());
            chk("m_id", evt_id, head / 2);
            chk("m_kind", evt_kind, head % 2);
            chk("m_ovf", ovf, m_ovf);
        end
    end

    initial begin
        int nev;
        int nrep;
        int exp_ev;
        int exp_rep;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_valid", evt_valid, 0);
        chk("rst_count", evt_count, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_id", evt_id, 0);
        chk("rst_kind", evt_kind, 0);
        rst = 1'b0;
        @(negedge clk);

        // single press, latency and pop
        btn_level = 4'b0010;
        @(negedge clk);
        chk("t1_lat_valid", evt_valid, 0);
        @(negedge clk);
        chk("t1_valid", evt_valid, 1);
        chk("t1_id", evt_id, 1);
        chk("t1_kind", evt_kind, 0);
        chk("t1_count", evt_count, 1);
        evt_ready = 1'b1;
        @(negedge clk);
        chk("t1_pop_count", evt_count, 0);
        chk("t1_pop_valid", evt_valid, 0);
        chk("t1_hold_id", evt_id, 1);
        evt_ready = 1'b0;
        btn_level = 4'b0000;

        // round-robin order with rr_ptr starting at 0, twice
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            btn_level = 4'b1111;
            evt_ready = 1'b1;
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("t2_order", evt_id, k);
                chk("t2_valid", evt_valid, 1);
            end
            @(negedge clk);
            chk("t2_drain", evt_count, 0);
            btn_level = 4'b0000;
            @(negedge clk);
        end

        // fill FIFO, fifth event pending, third press of button 2 drops
        evt_ready = 1'b0;
        btn_level = 4'b1111;
        repeat (5) @(negedge clk);
        chk("t3_full", evt_count, 4);
        btn_level = 4'b1011;
        @(negedge clk);
        btn_level = 4'b1111;
        @(negedge clk);
        chk("t3_pend_count", evt_count, 4);
        chk("t3_pend_ovf", ovf, 0);
        btn_level = 4'b1011;
        @(negedge clk);
        btn_level = 4'b1111;
        @(negedge clk);
        chk("t3_ovf_set", ovf, 1);
        chk("t3_ovf_count", evt_count, 4);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", ovf, 0);

        // full FIFO with pending: push and pop in the same cycle
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        chk("t4_count", evt_count, 4);
        chk("t4_head", evt_id, 1);
        chk("t4_ovf", ovf, 0);
        @(negedge clk);
        chk("t4_stable", evt_count, 4);

        // reset with count=3 and a pending request; button held through reset
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        btn_level = 4'b0000;
        @(negedge clk);
        chk("t5_count3", evt_count, 3);
        btn_level = 4'b0001;
        @(negedge clk);
        chk("t5_pre_rst", evt_count, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_valid", evt_valid, 0);
        chk("t5_count", evt_count, 0);
        chk("t5_ovf", ovf, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_lat", evt_count, 0);
        @(negedge clk);
        chk("t5_one", evt_count, 1);
        chk("t5_id", evt_id, 0);
        repeat (3) @(negedge clk);
        chk("t5_only_one", evt_count, 1);
        evt_ready = 1'b1;
        btn_level = 4'b0000;
        repeat (3) @(negedge clk);

        // hold button 3 for 25 cycles
        btn_level = 4'b1000;
        nev = 0;
        nrep = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (evt_valid) begin
                nev++;
                if (evt_kind) nrep++;
            end
            if (c == 24) btn_level = 4'b0000;
        end
`ifdef AUTO_REPEAT_EN
        exp_ev = 5;
        exp_rep = 4;
`else
        exp_ev = 1;
        exp_rep = 0;
`endif
        chk("t6_events", nev, exp_ev);
        chk("t6_repeats", nrep, exp_rep);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
